// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - SPI mode-0 master turning 16-bit word requests into serial SRAM frames
//
// Ports:
//   clk, resetb                : system clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  : request handshake (ready only while idle)
//   req_we_i, req_addr_i,
//   req_wdata_i                : request fields, captured at the handshake edge
//   rsp_valid_o, rsp_rdata_o   : one-cycle completion pulse, read word (held until next read)
//   mem_csb_o, mem_sclk_o,
//   mem_out_o, mem_in_i        : SPI chip select, clock, MOSI, MISO
module spi_mem_ctrl #(
    parameter int         CLK_DIV   = 1,
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] WRITE_CMD = 8'h02
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [14:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        mem_csb_o,
    output logic        mem_sclk_o,
    output logic        mem_out_o,
    input  logic        mem_in_i
);

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [5:0] FRAME_BITS = 6'd40;
    localparam logic [5:0] DATA_START = 6'd24;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [39:0] tx_sh;
    logic [15:0] rx_sh;
    logic        we_q;
    logic        handshake;
    logic        half_end;
    logic        frame_end;

    assign req_ready_o = (state_q == IDLE);
    assign handshake   = req_valid_i && req_ready_o;
    assign half_end    = (div_cnt == DIV_LAST);
    // bit_cnt counts sclk rises issued; after the 40th rise the low phase
    // that follows closes the frame instead of starting another slot.
    assign frame_end   = half_end && !mem_sclk_o && (bit_cnt == FRAME_BITS);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = SETUP;
            SETUP:   state_d = SHIFT;
            SHIFT:   if (frame_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            mem_csb_o   <= 1'b1;
            mem_sclk_o  <= 1'b0;
            mem_out_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 16'h0000;
            div_cnt     <= 8'd0;
            bit_cnt     <= 6'd0;
            tx_sh       <= 40'd0;
            rx_sh       <= 16'h0000;
            we_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        we_q  <= req_we_i;
                        // Reads shift out zeros during the data phase.
                        tx_sh <= {req_we_i ? WRITE_CMD : READ_CMD,
                                  req_addr_i, 1'b0,
                                  req_we_i ? req_wdata_i : 16'h0000};
                    end
                end
                SETUP: begin
                    mem_csb_o  <= 1'b0;
                    mem_sclk_o <= 1'b0;
                    mem_out_o  <= tx_sh[39];
                    // Preloaded so the very next edge raises sclk for slot 0.
                    div_cnt    <= DIV_LAST;
                    bit_cnt    <= 6'd0;
                end
                SHIFT: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (!mem_sclk_o) begin
                            if (bit_cnt == FRAME_BITS) begin
                                mem_csb_o   <= 1'b1;
                                mem_out_o   <= 1'b0;
                                rsp_valid_o <= 1'b1;
                                if (!we_q) rsp_rdata_o <= rx_sh;
                            end else begin
                                mem_sclk_o <= 1'b1;
                                bit_cnt    <= bit_cnt + 6'd1;
                                // MISO was launched on the previous falling edge.
                                if (bit_cnt >= DATA_START) rx_sh <= {rx_sh[14:0], mem_in_i};
                            end
                        end else begin
                            mem_sclk_o <= 1'b0;
                            if (bit_cnt != FRAME_BITS) begin
                                tx_sh     <= {tx_sh[38:0], 1'b0};
                                mem_out_o <= tx_sh[38];
                            end
                        end
                    end
                end
                DONE: begin
                    rsp_valid_o <= 1'b0;
                    div_cnt     <= 8'd0;
                    bit_cnt     <= 6'd0;
                end
                default: begin
                    mem_csb_o  <= 1'b1;
                    mem_sclk_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - directed self-checking bench for spi_mem_ctrl with a serial SRAM model
module tb_spi_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetb;
    logic        req_we;
    logic [14:0] req_addr;
    logic [15:0] req_wdata;

    logic        valid0, ready0, rsp_valid0, csb0, sclk0, mosi0;
    logic        miso0 = 1'b0;
    logic [15:0] rdata0;
    logic        valid1, ready1, rsp_valid1, csb1, sclk1, mosi1;
    logic        miso1 = 1'b0;
    logic [15:0] rdata1;

    spi_mem_ctrl #(.CLK_DIV(1)) u0 (
        .clk(clk), .resetb(resetb),
        .req_valid_i(valid0), .req_ready_o(ready0), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid0), .rsp_rdata_o(rdata0),
        .mem_csb_o(csb0), .mem_sclk_o(sclk0), .mem_out_o(mosi0), .mem_in_i(miso0)
    );

    spi_mem_ctrl #(.CLK_DIV(3)) u1 (
        .clk(clk), .resetb(resetb),
        .req_valid_i(valid1), .req_ready_o(ready1), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid1), .rsp_rdata_o(rdata1),
        .mem_csb_o(csb1), .mem_sclk_o(sclk1), .mem_out_o(mosi1), .mem_in_i(miso1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide SRAM contents served to reads; writes land in wr_mem.
    logic [7:0] rom    [0:65535];
    logic [7:0] wr_mem [0:65535];

    int          m0_cnt = 0, m0_rises = 0, m0_wr = 0;
    logic [39:0] m0_sh = '0, m0_frame = '0;
    logic [15:0] m0_rd = '0;

    always @(posedge sclk0 or posedge csb0) begin
        if (csb0) begin
            m0_cnt = 0;
        end else begin
            m0_sh    = {m0_sh[38:0], mosi0};
            m0_cnt   = m0_cnt + 1;
            m0_frame = m0_sh;
            m0_rises = m0_cnt;
            if (m0_cnt == 32 && m0_sh[31:24] == 8'h02) begin
                wr_mem[m0_sh[23:8]] = m0_sh[7:0];
                m0_wr++;
            end
            if (m0_cnt == 40 && m0_sh[39:32] == 8'h02) begin
                wr_mem[m0_sh[31:16] + 16'd1] = m0_sh[7:0];
                m0_wr++;
            end
        end
    end

    always @(negedge sclk0 or posedge csb0) begin
        if (csb0) begin
            miso0 = 1'b0;
        end else if (m0_cnt >= 24 && m0_cnt < 40) begin
            if (m0_cnt == 24) m0_rd = {rom[m0_sh[15:0]], rom[m0_sh[15:0] + 16'd1]};
            miso0 = m0_rd[39 - m0_cnt];
        end
    end

    int          m1_cnt = 0, m1_rises = 0;
    logic [39:0] m1_sh = '0;
    logic [15:0] m1_rd = '0;

    always @(posedge sclk1 or posedge csb1) begin
        if (csb1) begin
            m1_cnt = 0;
        end else begin
            m1_sh    = {m1_sh[38:0], mosi1};
            m1_cnt   = m1_cnt + 1;
            m1_rises = m1_cnt;
        end
    end

    always @(negedge sclk1 or posedge csb1) begin
        if (csb1) begin
            miso1 = 1'b0;
        end else if (m1_cnt >= 24 && m1_cnt < 40) begin
            if (m1_cnt == 24) m1_rd = {rom[m1_sh[15:0]], rom[m1_sh[15:0] + 16'd1]};
            miso1 = m1_rd[39 - m1_cnt];
        end
    end

    int hs0 = 0, rsp0 = 0;
    always @(posedge clk) begin
        if (valid0 && ready0) hs0++;
        if (rsp_valid0) rsp0++;
    end

    int gap = 0, last_gap = 0;
    always @(negedge clk) begin
        if (csb0 === 1'b1) gap++;
        else if (gap > 0) begin
            last_gap = gap;
            gap = 0;
        end
    end

    // sclk phase lengths on the divided instance, measured inside frames only.
    logic prev1 = 1'b0;
    bit   started1 = 1'b0;
    int   run1 = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
    always @(negedge clk) begin
        if (csb1 === 1'b0) begin
            if (sclk1 != prev1) begin
                if (prev1) begin
                    if (run1 < hi_min) hi_min = run1;
                    if (run1 > hi_max) hi_max = run1;
                end else if (started1) begin
                    if (run1 < lo_min) lo_min = run1;
                    if (run1 > lo_max) lo_max = run1;
                end
                if (sclk1) started1 = 1'b1;
                run1 = 1;
            end else begin
                run1++;
            end
            prev1 = sclk1;
        end else begin
            if (started1 && !prev1) begin
                if (run1 < lo_min) lo_min = run1;
                if (run1 > lo_max) lo_max = run1;
            end
            started1 = 1'b0;
            prev1    = 1'b0;
            run1     = 0;
        end
    end

    task automatic issue(input int sel, input logic we, input logic [14:0] a,
                         input logic [15:0] d, output int hs_cyc);
        int t;
        req_we = we; req_addr = a; req_wdata = d;
        if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
        t = 0;
        while (((sel == 0) ? ready0 : ready1) !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("issue_ready_timeout", (t < 1000), 1);
        @(posedge clk);
        @(negedge clk);
        hs_cyc = cyc;
        valid0 = 1'b0;
        valid1 = 1'b0;
    endtask

    task automatic wait_rsp(input int sel, output int rsp_cyc, output logic [15:0] rd);
        int t;
        t = 0;
        while (((sel == 0) ? rsp_valid0 : rsp_valid1) !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rsp_timeout", (t < 2000), 1);
        rsp_cyc = cyc;
        rd = (sel == 0) ? rdata0 : rdata1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          hs_c, rsp_c, k, hs_before, rsp_before, wr_before;
        logic [15:0] rd, rd_first;

        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
        rom[16'h000A] = 8'hAB; rom[16'h000B] = 8'hCD;
        rom[16'h0000] = 8'h11; rom[16'h0001] = 8'h22;
        rom[16'h0002] = 8'h33; rom[16'h0003] = 8'h44;

        resetb = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        check("rst_ready", ready0, 1);
        check("rst_csb", csb0, 1);
        check("rst_sclk", sclk0, 0);
        check("rst_mosi", mosi0, 0);
        check("rst_rsp_valid", rsp_valid0, 0);
        check("rst_rdata", rdata0, 16'h0000);

        // Read of word 5 -> byte address 000A.
        issue(0, 1'b0, 15'h0005, 16'h0000, hs_c);
        wait_rsp(0, rsp_c, rd);
        check("rd_latency", rsp_c - hs_c, 82);
        check("rd_data", rd, 16'hABCD);
        check("rd_frame", m0_frame, {8'h03, 16'h000A, 16'h0000});
        check("rd_rises", m0_rises, 40);
        check("rd_ready_during_rsp", ready0, 0);
        @(negedge clk);
        check("rd_rsp_one_cycle", rsp_valid0, 0);
        check("rd_ready_after_rsp", ready0, 1);

        // Write.
        rsp_before = rsp0;
        issue(0, 1'b1, 15'h7FFF, 16'h1234, hs_c);
        wait_rsp(0, rsp_c, rd);
        check("wr_frame", m0_frame, {8'h02, 16'hFFFE, 16'h1234});
        check("wr_rises", m0_rises, 40);
        check("wr_mem_hi", wr_mem[16'hFFFE], 8'h12);
        check("wr_mem_lo", wr_mem[16'hFFFF], 8'h34);
        check("wr_rdata_kept", rd, 16'hABCD);
        @(negedge clk);
        check("wr_rsp_pulses", rsp0 - rsp_before, 1);

        // Busy-ignore: valid held high with a changing address.
        hs_before = hs0;
        rd_first  = '0;
        req_we = 1'b0; req_addr = 15'h0005; valid0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (k < 300) begin
            req_addr = 15'h0100 + 15'(k);
            if (rsp_valid0) rd_first = rdata0;
            if (ready0) break;
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0;
        check("busy_first_rdata", rd_first, 16'hABCD);
        check("busy_reissue_cycle", k, 83);
        wait_rsp(0, rsp_c, rd);
        check("busy_second_addr", m0_frame[31:16], 16'h02A6);
        check("busy_handshakes", hs0 - hs_before, 2);
        @(negedge clk);

        // Back-to-back reads of words 0 and 1.
        issue(0, 1'b0, 15'h0000, 16'h0000, hs_c);
        wait_rsp(0, rsp_c, rd);
        check("b2b_first", rd, 16'h1122);
        issue(0, 1'b0, 15'h0001, 16'h0000, hs_c);
        wait_rsp(0, rsp_c, rd);
        check("b2b_second", rd, 16'h3344);
        check("b2b_cs_gap_min1", (last_gap >= 1), 1);
        @(negedge clk);

        // Divided clock instance.
        issue(1, 1'b0, 15'h0005, 16'h0000, hs_c);
        wait_rsp(1, rsp_c, rd);
        check("div3_latency", rsp_c - hs_c, 242);
        check("div3_data", rd, 16'hABCD);
        check("div3_rises", m1_rises, 40);
        check("div3_hi_min", hi_min, 3);
        check("div3_hi_max", hi_max, 3);
        check("div3_lo_min", lo_min, 3);
        check("div3_lo_max", lo_max, 3);
        @(negedge clk);

        // Asynchronous reset during slot 20 of a write.
        rsp_before = rsp0;
        wr_before  = m0_wr;
        issue(0, 1'b1, 15'h0010, 16'hBEEF, hs_c);
        k = 0;
        while (m0_cnt != 21 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("arst_reach_slot20", (k < 200), 1);
        #1 resetb = 1'b0;
        #1;
        check("arst_csb", csb0, 1);
        check("arst_sclk", sclk0, 0);
        check("arst_mosi", mosi0, 0);
        check("arst_rsp_valid", rsp_valid0, 0);
        check("arst_rdata", rdata0, 16'h0000);
        check("arst_ready", ready0, 1);
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        repeat (2) @(negedge clk);
        check("arst_no_rsp", rsp0 - rsp_before, 0);
        check("arst_no_write", m0_wr - wr_before, 0);
        issue(0, 1'b0, 15'h0005, 16'h0000, hs_c);
        wait_rsp(0, rsp_c, rd);
        check("arst_after_latency", rsp_c - hs_c, 82);
        check("arst_after_data", rd, 16'hABCD);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
